// File: rtl/project_pkg.sv
// Shared types for the matrix UART path: element type, sender command flags, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package project_pkg;

    localparam int NUM_UART_REQ = 3;

    typedef logic signed [15:0] matrix_element_t;

    typedef struct packed {
        logic is_last_col;
        logic newline_only;
        logic id;
        logic sum_head;
        logic sum_elem;
    } sender_cmd_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request searching upward from last_grant+1, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when no request is asserted.
module rr_picker
    import project_pkg::*;
#(
    parameter  int NUM_REQ = NUM_UART_REQ,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               found,
    output logic [IW-1:0]      index
);

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NUM_REQ]) begin
                found = 1'b1;
                index = IW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender among NUM_REQ requesters (round-robin with optional grant lock); UART_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: valid sampled in ARB -> start/ack next cycle; item takes >= 4 cycles (ARB, ISSUE, WAIT, DONE).
// Backpressure: requesters hold valid/data until ack; WAIT holds until sender_done (or watchdog expiry).
module uart_tx_arbiter
    import project_pkg::*;
#(
    parameter  int NUM_REQ     = NUM_UART_REQ,
    parameter  int TIMEOUT_CYC = 65535,
    localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_lock,
    input  matrix_element_t [NUM_REQ-1:0]     req_data,
    input  sender_cmd_t [NUM_REQ-1:0]         req_cmd,
    output logic [NUM_REQ-1:0]                req_ack,
    output logic [NUM_REQ-1:0]                req_done,
    output logic [NUM_REQ-1:0]                req_err,
    output matrix_element_t                   sender_data,
    output sender_cmd_t                       sender_cmd,
    output logic                              sender_start,
    input  logic                              sender_done,
    output logic [IW-1:0]                     grant_id,
    output logic                              busy
);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] lock_owner;
    logic          lock_vld;
    logic          lock_hold;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          sel_vld;
    logic [IW-1:0] sel_idx;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]   wd_cnt;
    logic          wd_expire;
    logic          err_flag;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (pick_vld),
        .index      (pick_idx)
    );

    // A lock only counts while its owner still asserts req_lock.
    assign lock_hold = lock_vld && req_lock[lock_owner];

    always_comb begin
        state_nxt    = state;
        sel_vld      = 1'b0;
        sel_idx      = grant_id;
        req_ack      = '0;
        req_done     = '0;
        req_err      = '0;
        sender_start = 1'b0;
        busy         = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wd_expire    = 1'b0;
`endif
        case (state)
            ARB: begin
                if (lock_hold) begin
                    sel_vld = req_valid[lock_owner];
                    sel_idx = lock_owner;
                end else begin
                    sel_vld = pick_vld;
                    sel_idx = pick_idx;
                end
                if (sel_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                sender_start      = 1'b1;
                busy              = 1'b1;
                req_ack[grant_id] = 1'b1;
                state_nxt         = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (sender_done) begin
                    state_nxt = DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (wd_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                req_done[grant_id] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                req_err[grant_id]  = err_flag;
`endif
                state_nxt          = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB;
            last_grant  <= IW'(NUM_REQ - 1);
            lock_owner  <= '0;
            lock_vld    <= 1'b0;
            grant_id    <= '0;
            sender_data <= '0;
            sender_cmd  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            err_flag    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (sel_vld) begin
                grant_id    <= sel_idx;
                sender_data <= req_data[sel_idx];
                sender_cmd  <= req_cmd[sel_idx];
            end
            if (state == ARB && lock_vld && !req_lock[lock_owner]) lock_vld <= 1'b0;
            if (state == DONE) begin
                last_grant <= grant_id;
                lock_owner <= grant_id;
                lock_vld   <= req_lock[grant_id];
            end
`ifdef UART_ARB_TIMEOUT_EN
            // A timed-out owner loses its lock so a stuck sender cannot starve others.
            if (state == DONE && err_flag) lock_vld <= 1'b0;
            if (state == ISSUE) begin
                wd_cnt   <= '0;
                err_flag <= 1'b0;
            end else if (state == WAIT) begin
                wd_cnt   <= wd_cnt + 16'd1;
                err_flag <= wd_expire;
            end
`endif
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing the matrix UART sender (index 0 = display, 1 = calculator result, 2 = input echo).
REQ-002 Parameter TIMEOUT_CYC, default 65535: watchdog limit in clk cycles; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single system clock; every register is clocked on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NUM_REQ  level per requester: "item pending".
REQ-006 req_lock  in  NUM_REQ  level per requester: keep the grant across consecutive items.
REQ-007 req_data  in  NUM_REQ x matrix_element_t  element or value to print.
REQ-008 req_cmd  in  NUM_REQ x sender_cmd_t  mode flags: is_last_col, newline_only, id, sum_head, sum_elem.
REQ-009 req_ack  out  NUM_REQ  one-cycle pulse: item latched.
REQ-010 req_done  out  NUM_REQ  one-cycle pulse: item fully transmitted.
REQ-011 req_err  out  NUM_REQ  one-cycle pulse coincident with req_done on timeout.
REQ-012 sender_data  out  matrix_element_t  latched value to the sender.
REQ-013 sender_cmd  out  sender_cmd_t  latched flags to the sender.
REQ-014 sender_start  out  1  one-cycle start pulse to the sender.
REQ-015 sender_done  in  1  sender completion pulse.
REQ-016 grant_id  out  $clog2(NUM_REQ)  current or last owner.
REQ-017 busy  out  1  high in ISSUE and WAIT.

Function
REQ-018 States SHALL be ARB, ISSUE, WAIT and DONE.
REQ-019 ARB SHALL select g by round-robin among asserted req_valid, searching upward from last_grant+1 modulo NUM_REQ.
- Exception: if lock_owner is set and req_valid[lock_owner] is high, g SHALL be lock_owner.
REQ-020 In ARB with no valid request, the block SHALL stay in ARB with all pulses low.
REQ-021 On selection, the block SHALL latch req_data[g] and req_cmd[g], set grant_id=g, and go to ISSUE.
REQ-022 ISSUE SHALL last one cycle, with sender_start=1 and req_ack[g]=1 in that cycle.
- Latency: valid sampled in cycle t gives start/ack in cycle t+1.
REQ-023 WAIT SHALL hold until sender_done=1, then go to DONE.
REQ-024 sender_done SHALL be ignored in ARB, ISSUE and DONE.
REQ-025 DONE SHALL last one cycle: req_done[g]=1, last_grant<=g, then return to ARB.
- If req_lock[g] is high in DONE, lock_owner<=g; otherwise lock_owner is cleared.
REQ-026 While lock_owner is set and its req_valid is low, the block SHALL idle in ARB without granting others.
- The lock releases when req_lock[lock_owner] drops.
REQ-027 Requesters SHALL hold req_data/req_cmd stable while valid is unacked.
- A valid still high in the cycle after DONE SHALL be treated as a new item.
REQ-028 sender_data and sender_cmd SHALL stay stable from ISSUE through DONE.
REQ-029 Minimum turnaround SHALL be 4 cycles per item: ARB, ISSUE, WAIT (at least 1 cycle), DONE.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set: state=ARB, last_grant=NUM_REQ-1 (requester 0 first), lock_owner cleared, grant_id=0, sender_data=0, sender_cmd=0, and all pulses, busy and req_err low.
REQ-031 Reset mid-transfer SHALL abandon the item without req_done.
- The sender is reset by its own rst; the arbiter does not drive it.

Configuration
REQ-032 With UART_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear in ISSUE and increment in WAIT.
- Reaching TIMEOUT_CYC without sender_done SHALL go to DONE with req_done[g]=1 and req_err[g]=1, and SHALL clear lock_owner.
REQ-033 Without UART_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, no counter SHALL exist, and req_err SHALL be tied to 0.

Structure
REQ-034 sender_cmd_t (packed struct of the five flags), arb_state_t and the constant NUM_UART_REQ=3 SHALL reside in project_pkg alongside matrix_element_t.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, last_grant; outputs: found, index).

Verification
REQ-036 Single request: req_valid[1]=1 with data=-7 and is_last_col=1; sender_done 10 cycles after start -> start/ack one cycle after valid; sender_data=-7; req_done[1] in the cycle after sender_done.
REQ-037 Fairness: req_valid=3'b111 held continuously for 6 items, starting from reset -> grant order 0,1,2,0,1,2.
REQ-038 Lock: requester 0 sends 9 items with req_lock=1 while requester 2 is also valid -> all 9 items go to requester 0 first; requester 2 is granted on the next ARB after the lock drops.
REQ-039 Spurious done: sender_done pulsed in ARB and in DONE -> no state change and no extra req_done.
REQ-040 Reset mid-WAIT: rst asserted 3 cycles after start -> next cycle all outputs 0, no req_done; requester 0 gets the next grant.
REQ-041 Timeout (macro defined, TIMEOUT_CYC=20): sender_done never arrives -> req_done[g] and req_err[g] 21 cycles after ISSUE; lock released; without the macro the block stays in WAIT.
